// File: rtl/clock_divider_multi_pkg.sv
// Shared types, defaults and helpers for the multi-channel clock divider.
package clkdiv_pkg;

  localparam int unsigned CNT_W_DEF       = 32;
  localparam int unsigned RESET_RATIO_DEF = 2;
  localparam int unsigned MAX_CNT_W       = 64;

  typedef logic [CNT_W_DEF-1:0] ratio_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } ch_state_e;

  // High-phase length ceil(R/2), one bit wider so R = all-ones cannot overflow.
  function automatic logic [MAX_CNT_W:0] halfperiod(input logic [MAX_CNT_W-1:0] r);
    logic [MAX_CNT_W:0] r_ext;
    r_ext = {1'b0, r};
    return (r_ext + (MAX_CNT_W+1)'(1)) >> 1;
  endfunction

endpackage

// File: rtl/clock_divider_multi_if.sv
// Control/status bundle between the divider and its user.
interface clock_divider_multi_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 32
);
  logic [NUM_CH-1:0]       enable;
  logic [NUM_CH*CNT_W-1:0] ratio_in;
  logic [NUM_CH-1:0]       ratio_load;
  logic                    sync;
  logic [NUM_CH-1:0]       clk_out;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       ratio_err;

  modport master (
    output enable, ratio_in, ratio_load, sync,
    input  clk_out, tick, ratio_err
  );

  modport slave (
    input  enable, ratio_in, ratio_load, sync,
    output clk_out, tick, ratio_err
  );
endinterface

// File: rtl/clock_divider_multi_channel.sv
// One divider channel: counter, pending/active ratio and registered outputs.
module clock_divider_channel
  import clkdiv_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned RESET_RATIO = RESET_RATIO_DEF
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [CNT_W-1:0] ratio_in,
  input  logic             ratio_load,
  input  logic             sync,
  output logic             clk_out,
  output logic             tick,
  output logic             ratio_err
);

  ch_state_e          state;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   ratio;
  logic [CNT_W-1:0]   pending_ratio;
  logic               pending;

  logic               wrap;
  logic               apply;
  logic [CNT_W-1:0]   count_next;
  logic [CNT_W-1:0]   ratio_eff;
  logic [MAX_CNT_W:0] half;

  always_comb begin
    wrap       = (count == ratio - CNT_W'(1)) || sync;
    count_next = wrap ? '0 : count + CNT_W'(1);
    // A pending ratio lands only at a period boundary of a running channel,
    // or immediately when the channel is idle or halted.
    apply      = pending && ((state != ST_RUN) || (enable && wrap));
    ratio_eff  = apply ? pending_ratio : ratio;
    half       = halfperiod(MAX_CNT_W'(ratio_eff));
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      count         <= '0;
      ratio         <= CNT_W'(RESET_RATIO);
      pending_ratio <= '0;
      pending       <= 1'b0;
      clk_out       <= 1'b0;
      tick          <= 1'b0;
      ratio_err     <= 1'b0;
    end else begin
      if (ratio_load) begin
        pending_ratio <= ratio_in;
        pending       <= 1'b1;
      end else if (apply) begin
        pending <= 1'b0;
      end

      ratio <= ratio_eff;

      if (ratio_eff == '0) begin
        state     <= ST_HALT;
        count     <= '0;
        clk_out   <= 1'b0;
        tick      <= 1'b0;
        ratio_err <= 1'b1;
      end else begin
        ratio_err <= 1'b0;
        case (state)
          ST_RUN: begin
            if (enable) begin
              count   <= count_next;
              clk_out <= ((MAX_CNT_W+1)'(count_next) < half);
              tick    <= (count_next == '0);
            end else begin
              tick <= 1'b0;
            end
          end
          default: begin
            if (enable) begin
              state   <= ST_RUN;
              count   <= '0;
              clk_out <= 1'b1;
              tick    <= 1'b1;
            end else begin
              state <= ST_IDLE;
              tick  <= 1'b0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider: slices the bus and fans out sync.
module clock_divider_multi
  import clkdiv_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned RESET_RATIO = RESET_RATIO_DEF
) (
  input logic                   clk_in,
  input logic                   reset_n,
  clock_divider_multi_if.slave  bus
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clock_divider_channel #(
      .CNT_W       (CNT_W),
      .RESET_RATIO (RESET_RATIO)
    ) u_ch (
      .clk_in     (clk_in),
      .reset_n    (reset_n),
      .enable     (bus.enable[i]),
      .ratio_in   (bus.ratio_in[i*CNT_W +: CNT_W]),
      .ratio_load (bus.ratio_load[i]),
      .sync       (bus.sync),
      .clk_out    (bus.clk_out[i]),
      .tick       (bus.tick[i]),
      .ratio_err  (bus.ratio_err[i])
    );
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed scoreboard bench for clock_divider_multi (4 channels, 8-bit ratios).
module tb_clock_divider_multi;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CNT_W  = 8;

  logic clk_in = 1'b0;
  logic reset_n;

  clock_divider_multi_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  clock_divider_multi #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .RESET_RATIO (2)
  ) dut (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [3:0] clk;
    logic [3:0] tck;
    logic [3:0] err;
    int         id;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         step_no = 0;
  logic [7:0] rat [4];

  task automatic step(input logic [3:0] en, input logic [3:0] ld, input logic sy,
                      input logic [3:0] eclk, input logic [3:0] etick, input logic [3:0] eerr);
    exp_t e;
    bus.enable     = en;
    bus.ratio_load = ld;
    bus.sync       = sy;
    bus.ratio_in   = {rat[3], rat[2], rat[1], rat[0]};
    e.clk = eclk;
    e.tck = etick;
    e.err = eerr;
    e.id  = step_no;
    q.push_back(e);
    step_no++;
    @(negedge clk_in);
  endtask

  // Monitor: every cycle the divider presents a new output vector.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_in);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (bus.clk_out !== e.clk || bus.tick !== e.tck || bus.ratio_err !== e.err) begin
          errors++;
          $display("FAIL step%0d: clk_out=%b want %b, tick=%b want %b, ratio_err=%b want %b",
                   e.id, bus.clk_out, e.clk, bus.tick, e.tck, bus.ratio_err, e.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n        = 1'b0;
    bus.enable     = '0;
    bus.ratio_load = '0;
    bus.sync       = 1'b0;
    bus.ratio_in   = '0;
    for (int i = 0; i < 4; i++) rat[i] = 8'd0;
    @(negedge clk_in);

    // Reset state
    step(4'h0, 4'h0, 0, 4'h0, 4'h0, 4'h0);
    step(4'h0, 4'h0, 0, 4'h0, 4'h0, 4'h0);

    // ch0 R=4, others R=2
    reset_n = 1'b1;
    rat[0] = 8'd4;
    step(4'h0, 4'h1, 0, 4'h0, 4'h0, 4'h0);
    step(4'hF, 4'h0, 0, 4'hF, 4'hF, 4'h0);
    step(4'hF, 4'h0, 0, 4'h1, 4'h0, 4'h0);
    step(4'hF, 4'h0, 0, 4'hE, 4'hE, 4'h0);
    step(4'hF, 4'h0, 0, 4'h0, 4'h0, 4'h0);
    step(4'hF, 4'h0, 0, 4'hF, 4'hF, 4'h0);
    step(4'hF, 4'h0, 0, 4'h1, 4'h0, 4'h0);
    step(4'hF, 4'h0, 0, 4'hE, 4'hE, 4'h0);
    step(4'hF, 4'h0, 0, 4'h0, 4'h0, 4'h0);
    step(4'hF, 4'h0, 0, 4'hF, 4'hF, 4'h0);

    // ch0 alone; ch1..3 frozen high with no tick. R=5 then R=3
    rat[0] = 8'd5;
    step(4'h1, 4'h1, 0, 4'hF, 4'h0, 4'h0);
    step(4'h1, 4'h0, 0, 4'hE, 4'h0, 4'h0);
    step(4'h1, 4'h0, 0, 4'hE, 4'h0, 4'h0);
    step(4'h1, 4'h0, 0, 4'hF, 4'h1, 4'h0);
    step(4'h1, 4'h0, 0, 4'hF, 4'h0, 4'h0);
    step(4'h1, 4'h0, 0, 4'hF, 4'h0, 4'h0);
    step(4'h1, 4'h0, 0, 4'hE, 4'h0, 4'h0);
    step(4'h1, 4'h0, 0, 4'hE, 4'h0, 4'h0);
    step(4'h1, 4'h0, 0, 4'hF, 4'h1, 4'h0);
    rat[0] = 8'd3;
    step(4'h1, 4'h1, 0, 4'hF, 4'h0, 4'h0);
    step(4'h1, 4'h0, 0, 4'hF, 4'h0, 4'h0);
    step(4'h1, 4'h0, 0, 4'hE, 4'h0, 4'h0);
    step(4'h1, 4'h0, 0, 4'hE, 4'h0, 4'h0);
    step(4'h1, 4'h0, 0, 4'hF, 4'h1, 4'h0);
    step(4'h1, 4'h0, 0, 4'hF, 4'h0, 4'h0);
    step(4'h1, 4'h0, 0, 4'hE, 4'h0, 4'h0);
    step(4'h1, 4'h0, 0, 4'hF, 4'h1, 4'h0);
    step(4'h1, 4'h0, 0, 4'hF, 4'h0, 4'h0);
    step(4'h1, 4'h0, 0, 4'hE, 4'h0, 4'h0);
    step(4'h1, 4'h0, 0, 4'hF, 4'h1, 4'h0);

    // R=1, then R=0 halt (enable ignored), then R=2 recovery
    rat[0] = 8'd1;
    step(4'h1, 4'h1, 0, 4'hF, 4'h0, 4'h0);
    step(4'h1, 4'h0, 0, 4'hE, 4'h0, 4'h0);
    step(4'h1, 4'h0, 0, 4'hF, 4'h1, 4'h0);
    step(4'h1, 4'h0, 0, 4'hF, 4'h1, 4'h0);
    rat[0] = 8'd0;
    step(4'h1, 4'h1, 0, 4'hF, 4'h1, 4'h0);
    step(4'h1, 4'h0, 0, 4'hE, 4'h0, 4'h1);
    step(4'h1, 4'h0, 0, 4'hE, 4'h0, 4'h1);
    rat[0] = 8'd2;
    step(4'h1, 4'h1, 0, 4'hE, 4'h0, 4'h1);
    step(4'h1, 4'h0, 0, 4'hF, 4'h1, 4'h0);
    step(4'h1, 4'h0, 0, 4'hE, 4'h0, 4'h0);
    step(4'h1, 4'h0, 0, 4'hF, 4'h1, 4'h0);
    step(4'h1, 4'h0, 0, 4'hE, 4'h0, 4'h0);

    // Load on a wrap applies one period later; R=4 -> R=6 loaded mid-period
    rat[0] = 8'd4;
    step(4'h1, 4'h1, 0, 4'hF, 4'h1, 4'h0);
    step(4'h1, 4'h0, 0, 4'hE, 4'h0, 4'h0);
    step(4'h1, 4'h0, 0, 4'hF, 4'h1, 4'h0);
    step(4'h1, 4'h0, 0, 4'hF, 4'h0, 4'h0);
    rat[0] = 8'd6;
    step(4'h1, 4'h1, 0, 4'hE, 4'h0, 4'h0);
    step(4'h1, 4'h0, 0, 4'hE, 4'h0, 4'h0);
    step(4'h1, 4'h0, 0, 4'hF, 4'h1, 4'h0);
    step(4'h1, 4'h0, 0, 4'hF, 4'h0, 4'h0);
    step(4'h1, 4'h0, 0, 4'hF, 4'h0, 4'h0);
    step(4'h1, 4'h0, 0, 4'hE, 4'h0, 4'h0);
    step(4'h1, 4'h0, 0, 4'hE, 4'h0, 4'h0);
    step(4'h1, 4'h0, 0, 4'hE, 4'h0, 4'h0);
    step(4'h1, 4'h0, 0, 4'hF, 4'h1, 4'h0);

    // Reset mid-period with pending loads: pending discarded, R back to 2
    rat[0] = 8'd3;
    rat[1] = 8'd6;
    step(4'h1, 4'h3, 0, 4'hF, 4'h0, 4'h0);
    reset_n = 1'b0;
    step(4'h1, 4'h0, 0, 4'h0, 4'h0, 4'h0);
    reset_n = 1'b1;
    step(4'h3, 4'h0, 0, 4'h3, 4'h3, 4'h0);
    step(4'h3, 4'h0, 0, 4'h0, 4'h0, 4'h0);
    step(4'h3, 4'h0, 0, 4'h3, 4'h3, 4'h0);

    // ch0 R=3, ch1 R=6; ch1 paused in high phase, then sync realigns both
    step(4'h3, 4'h3, 0, 4'h0, 4'h0, 4'h0);
    step(4'h3, 4'h0, 0, 4'h3, 4'h3, 4'h0);
    step(4'h3, 4'h0, 0, 4'h3, 4'h0, 4'h0);
    step(4'h1, 4'h0, 0, 4'h2, 4'h0, 4'h0);
    step(4'h1, 4'h0, 0, 4'h3, 4'h1, 4'h0);
    step(4'h3, 4'h0, 0, 4'h3, 4'h0, 4'h0);
    step(4'h3, 4'h0, 0, 4'h0, 4'h0, 4'h0);
    step(4'h3, 4'h0, 0, 4'h1, 4'h1, 4'h0);
    step(4'h3, 4'h0, 1, 4'h3, 4'h3, 4'h0);
    step(4'h3, 4'h0, 0, 4'h3, 4'h0, 4'h0);
    step(4'h3, 4'h0, 0, 4'h2, 4'h0, 4'h0);
    step(4'h3, 4'h0, 0, 4'h1, 4'h1, 4'h0);

    // Largest ratio 255 on ch2: high 128, low 127
    rat[2] = 8'd255;
    step(4'h0, 4'h4, 0, 4'h1, 4'h0, 4'h0);
    step(4'h4, 4'h0, 0, 4'h5, 4'h4, 4'h0);
    for (int k = 1; k < 255; k++)
      step(4'h4, 4'h0, 0, (k < 128) ? 4'h5 : 4'h1, 4'h0, 4'h0);
    step(4'h4, 4'h0, 0, 4'h5, 4'h4, 4'h0);

    @(negedge clk_in);
    @(negedge clk_in);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
